// File: rtl/shared_resource_queued.sv
// ---------------------------------------------------------------------------
// shared_resource_queued
//
// Purpose: queued shared resource. Requests (address + tag) enter a small
// FIFO. A fixed-latency engine takes them one at a time and computes
// address + OFFSET. Each result is held on a valid/ready output until the
// consumer accepts it. Results leave in acceptance order.
//
// Optional feature (macro RESOURCE_FLUSH_EN): when the macro is defined,
// in_flush discards every queued and in-flight request. When the macro is
// undefined, in_flush is ignored.
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    request present
//   in_ready    request can be accepted (FIFO not full and not flushing)
//   in_address  request address
//   in_id       request tag
//   in_flush    discard all work (RESOURCE_FLUSH_EN only)
//   out_valid   result present
//   out_ready   consumer accepts result
//   out_data    zero-extended address + OFFSET, mod 2^DATA_WIDTH
//   out_id      tag of the result
//   count       FIFO occupancy
//   busy        engine not idle, or FIFO not empty
// ---------------------------------------------------------------------------
module shared_resource_queued #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DELAY         = 4,
  parameter logic [DATA_WIDTH-1:0] OFFSET = DATA_WIDTH'(16'h0200)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned CNTW = $clog2(DELAY + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CNTW-1:0] DELAY_C = CNTW'(DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_PROC, ST_DONE} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]      out_id_q, out_id_d;

  logic [ADDRESS_WIDTH-1:0] mem_addr [DEPTH];
  logic [ID_WIDTH-1:0]      mem_id   [DEPTH];

  logic flush_act;
  logic push;
  logic pop;
  logic load_result;

`ifdef RESOURCE_FLUSH_EN
  assign flush_act = in_flush;
`else
  logic unused_flush;
  assign flush_act    = 1'b0;
  assign unused_flush = in_flush;
`endif

  // Full blocks a push even when a pop happens on the same edge.
  assign in_ready = (count_q < DEPTH_C) && !flush_act;
  assign push     = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (count_q != '0)      state_d = ST_PROC;
      ST_PROC: if (cnt_q == DELAY_C)   state_d = ST_DONE;
      ST_DONE: if (out_ready)          state_d = (count_q != '0) ? ST_PROC : ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    if (flush_act) state_d = ST_IDLE;
  end

  // FSM: outputs. A flush cancels any pop or result load on the same edge.
  always_comb begin
    pop         = 1'b0;
    load_result = 1'b0;
    case (state_q)
      ST_IDLE: pop         = (count_q != '0);
      ST_PROC: load_result = (cnt_q == DELAY_C);
      ST_DONE: pop         = out_ready && (count_q != '0);
      default: ;
    endcase
    if (flush_act) begin
      pop         = 1'b0;
      load_result = 1'b0;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE) || (count_q != '0);

  // Datapath next state
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    id_d       = id_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (flush_act) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        addr_d   = mem_addr[rd_ptr_q];
        id_d     = mem_id[rd_ptr_q];
        cnt_d    = CNTW'(1);
      end else if (state_q == ST_PROC && !load_result) begin
        cnt_d = cnt_q + CNTW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
      if (load_result) begin
        out_data_d = DATA_WIDTH'(addr_q) + OFFSET;
        out_id_d   = id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      id_q       <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  // FIFO storage. It has no reset; the head is only read while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= in_address;
      mem_id[wr_ptr_q]   <= in_id;
    end
  end

endmodule

// File: doc/shared_resource_queued.md
# shared_resource_queued

Parametrised successor of the single-request shared resource. It has an input request FIFO of configurable depth, a fixed-latency processing engine, and a valid/ready output handshake with downstream backpressure. It sits between the requesting pipeline stages and the consumers of resource results. It has an optional flush path that discards all queued and in-flight requests.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 8: request address width.
- `DATA_WIDTH`, 16: result width; must be ≥ `ADDRESS_WIDTH`.
- `ID_WIDTH`, 4: request tag width.
- `DEPTH`, 4: input FIFO entries; power of two, ≥ 2.
- `DELAY`, 4: processing cycles; ≥ 1.
- `OFFSET`, 16'h0200: constant added to each address.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request can be accepted.
- `in_address`  in  `ADDRESS_WIDTH`  request address.
- `in_id`  in  `ID_WIDTH`  request tag.
- `in_flush`  in  1  discard all work; only active with `RESOURCE_FLUSH_EN`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  `DATA_WIDTH`  result.
- `out_id`  out  `ID_WIDTH`  tag of the result.
- `count`  out  `$clog2(DEPTH)+1`  FIFO occupancy.
- `busy`  out  1  high when the engine is not in IDLE or `count` != 0.

## Operation
Reset (`reset_n` low) acts immediately. Reset values:
- `out_valid`, `out_data`, `out_id`, `count`, `busy` = 0.
- Engine state = IDLE.
- `in_ready` = 1.

Request FIFO:
- `in_ready` = (`count` < `DEPTH`) and not flushing. It is combinational from registered state.
- Push occurs when `in_valid` && `in_ready`.
- There is no full-bypass: while full, a pop in the same cycle does not enable a push.
- Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap modulo `DEPTH`.

Engine FSM:
- IDLE: if `count` != 0, pop the head, latch address and id, set counter = 1, go to PROC.
- PROC: counter increments each cycle. At the edge where counter == `DELAY`, go to DONE. At that edge, register `out_data` = zero-extended address + `OFFSET` (mod 2^`DATA_WIDTH`), `out_id` = the latched id, and `out_valid` = 1.
- DONE: `out_valid`, `out_data` and `out_id` stay stable until `out_valid` && `out_ready`. On that handshake edge, `out_valid` drops to 0.
  - If `count` != 0, the same edge pops the next request and goes to PROC with counter = 1.
  - Otherwise go to IDLE.
- `out_data` and `out_id` keep their last value while `out_valid` is 0.
- Results are delivered strictly in acceptance order.

## Timing
- Into an idle, empty block: `out_valid` rises DELAY+1 edges after the accepting edge.
- Back-to-back with `out_ready` held high: one result every DELAY+1 cycles.
- After a delayed handshake with work queued: the next `out_valid` rises DELAY edges after the handshake edge.
- Maximum outstanding requests: `DEPTH` + 1 (FIFO plus engine).
- An asynchronous reset in any state returns all outputs to their reset values without waiting for a clock edge. The first request after deassertion is accepted on the next edge.

## Configuration
- Macro `RESOURCE_FLUSH_EN` defined:
  - `in_flush` sampled high at an edge empties the FIFO, forces the engine to IDLE, and clears `out_valid` and `count`.
  - `in_ready` is 0 while `in_flush` is high, so there is no push that cycle.
  - Flush overrides a same-cycle output handshake and pop. A handshake in that cycle is treated as consumed.
- Macro undefined: `in_flush` is ignored and has no effect on any state or output.

## Test plan
Defaults unless stated: DEPTH=4, DELAY=4, OFFSET=0x200.
- Single request, address 0x12, id 3, `out_ready`=1 → `out_valid` high for exactly 1 cycle, 5 edges after acceptance, with `out_data`=0x0212 and `out_id`=3. Then `busy`=0.
- Push ids 0..5 on consecutive cycles with `out_ready`=0 → ids 0-4 accepted, `count`=4, `in_ready`=0, id 5 held. Release `out_ready` → `out_id` sequence 0,1,2,3,4, then id 5 accepted.
- Hold `out_ready`=0 for 10 cycles while `out_valid`=1 → `out_data` and `out_id` unchanged throughout. Release with one request queued → next `out_valid` 4 edges after the handshake.
- OFFSET=0xFF80, address 0x90 → `out_data`=0x0010 (wrap, no overflow flag).
- With `RESOURCE_FLUSH_EN`, pulse `in_flush` during PROC with 2 requests queued → next cycle `count`=0, `busy`=0, and no `out_valid` for 20 cycles. Without the macro, the same stimulus yields 3 results.
- Drive `reset_n` low mid-DONE, between clock edges → `out_valid`=0 and `count`=0 before the next edge.
